// File: rtl/sr_pulse_driver.sv
// Command-side driver for an SR flip-flop: takes set/clear requests, drives an
// exclusive s or r pulse, waits a settle gap, then reads q back and reports.
module sr_pulse_driver #(
  parameter int PULSE_W = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_val,
  input  logic [7:0]       req_gap,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       fsm_state
);

  localparam int PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [PCW-1:0]   PCNT_LOAD = PCW'(PULSE_W - 1);
  localparam logic [PCW-1:0]   PCNT_ONE  = PCW'(1);
  localparam logic [CNT_W-1:0] ERR_MAX   = '1;
  localparam logic [CNT_W-1:0] ERR_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [PCW-1:0]   pcnt, pcnt_nx;
  logic [7:0]       gap_q, gap_nx;
  logic             val_q, val_nx;
  logic             s_nx, r_nx, done_nx, mm_nx;
  logic [CNT_W-1:0] err_nx;

  // Handshake: a request transfers on any posedge where req_valid & req_ready
  // and rst is low; req_valid may stay high, nothing is taken outside IDLE.
  assign req_ready = (state == IDLE);
  assign fsm_state = state;

  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    gap_nx   = gap_q;
    val_nx   = val_q;
    s_nx     = s;
    r_nx     = r;
    done_nx  = 1'b0;
    mm_nx    = 1'b0;
    err_nx   = err_cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          val_nx   = req_val;
          gap_nx   = req_gap;
          pcnt_nx  = PCNT_LOAD;
          s_nx     = req_val;
          r_nx     = ~req_val;
          state_nx = PULSE;
        end
      end
      PULSE: begin
        if (pcnt == '0) begin
          s_nx     = 1'b0;
          r_nx     = 1'b0;
          state_nx = (gap_q != 8'd0) ? SETTLE : CHECK;
        end else begin
          pcnt_nx = pcnt - PCNT_ONE;
        end
      end
      SETTLE: begin
        s_nx   = 1'b0;
        r_nx   = 1'b0;
        gap_nx = gap_q - 8'd1;
        if (gap_q == 8'd1) state_nx = CHECK;
      end
      CHECK: begin
        s_nx     = 1'b0;
        r_nx     = 1'b0;
        done_nx  = 1'b1;
        mm_nx    = (q_fb != val_q);
        if ((q_fb != val_q) && (err_cnt != ERR_MAX)) err_nx = err_cnt + ERR_ONE;
        state_nx = IDLE;
      end
      default: begin
        s_nx     = 1'b0;
        r_nx     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pcnt     <= '0;
      gap_q    <= '0;
      val_q    <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nx;
      pcnt     <= pcnt_nx;
      gap_q    <= gap_nx;
      val_q    <= val_nx;
      s        <= s_nx;
      r        <= r_nx;
      done     <= done_nx;
      mismatch <= mm_nx;
      err_cnt  <= err_nx;
    end
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: a cycle-indexed timing model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sr_pulse_driver;

  localparam int PW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_val = 1'b0;
  logic [7:0] req_gap = 8'd0;
  logic       q_fb;
  logic       q_zero = 1'b0;
  logic       req_ready, s, r, done, mismatch;
  logic [7:0] err_cnt;
  logic [1:0] fsm_state;
  logic       req_ready2, s2, r2, done2, mismatch2;
  logic [1:0] err_cnt2;
  logic [1:0] fsm_state2;

  logic flop_q = 1'b0;
  logic force_q0 = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  sr_pulse_driver #(.PULSE_W(PW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_val(req_val), .req_gap(req_gap), .q_fb(q_fb), .s(s), .r(r),
    .done(done), .mismatch(mismatch), .err_cnt(err_cnt), .fsm_state(fsm_state)
  );

  // Same request stream, readback tied low, narrow counter to hit saturation.
  sr_pulse_driver #(.PULSE_W(PW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_val(req_val), .req_gap(req_gap), .q_fb(q_zero), .s(s2), .r(r2),
    .done(done2), .mismatch(mismatch2), .err_cnt(err_cnt2), .fsm_state(fsm_state2)
  );

  always #5 clk = ~clk;

  // External SR flop: q follows the pulse one edge after it is sampled.
  always @(posedge clk) begin
    if (s) flop_q <= 1'b1;
    else if (r) flop_q <= 1'b0;
  end
  assign q_fb = force_q0 ? 1'b0 : flop_q;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Timing model: everything follows from the accept edge index.
  int  edge_n = 0;
  int  acc_edge = 0;
  int  m_gap = 0;
  bit  m_val = 1'b0;
  bit  busy = 1'b0;
  bit  chk_en = 1'b0;
  int  m_err = 0;
  int  m_err2 = 0;
  bit  e_s = 1'b0, e_r = 1'b0, e_done = 1'b0, e_mm = 1'b0, e_mm2 = 1'b0, e_ready = 1'b1;
  bit  pulse_on;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      busy = 1'b0; m_err = 0; m_err2 = 0;
      e_s = 1'b0; e_r = 1'b0; e_done = 1'b0; e_mm = 1'b0; e_mm2 = 1'b0; e_ready = 1'b1;
      chk_en = 1'b1;
    end else begin
      e_done = 1'b0; e_mm = 1'b0; e_mm2 = 1'b0;
      if (busy) begin
        if (edge_n - acc_edge == PW + m_gap + 1) begin
          e_done = 1'b1;
          e_mm   = (q_fb != m_val);
          if (e_mm && m_err < 255) m_err++;
          e_mm2  = m_val;
          if (m_val && m_err2 < 3) m_err2++;
          busy   = 1'b0;
        end
      end else if (req_valid) begin
        busy = 1'b1; acc_edge = edge_n; m_val = req_val; m_gap = int'(req_gap);
      end
      pulse_on = busy && (edge_n - acc_edge) < PW;
      e_s = pulse_on && m_val;
      e_r = pulse_on && !m_val;
      e_ready = !busy;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("s", s, e_s);
      check("r", r, e_r);
      check("s_and_r", s & r, 0);
      check("done", done, e_done);
      check("mismatch", mismatch, e_mm);
      check("err_cnt", err_cnt, m_err);
      check("req_ready", req_ready, e_ready);
      check("sat_s", s2, e_s);
      check("sat_done", done2, e_done);
      check("sat_mismatch", mismatch2, e_mm2);
      check("sat_err_cnt", err_cnt2, m_err2);
    end
  end

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    check("ready_timeout", ok, 1);
  endtask

  task automatic do_req(input logic v, input logic [7:0] g, output int done_at,
                        output int s_cnt, output int r_cnt, output logic mm_at);
    done_at = -1; s_cnt = 0; r_cnt = 0; mm_at = 1'b0;
    wait_ready();
    req_val = v; req_gap = g; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (s) s_cnt++;
      if (r) r_cnt++;
      if (done) begin done_at = i; mm_at = mismatch; break; end
    end
  endtask

  int   d_at, sc, rc, dn, last, extra;
  logic mm;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_s", s, 0);
    check("rst_r", r, 0);
    check("rst_done", done, 0);
    check("rst_err", err_cnt, 0);
    check("rst_ready", req_ready, 1);
    rst = 1'b0;

    do_req(1'b1, 8'd0, d_at, sc, rc, mm);
    check("set_done_at", d_at, 4);
    check("set_s_cycles", sc, 2);
    check("set_r_cycles", rc, 0);
    check("set_mismatch", mm, 0);
    check("set_err", err_cnt, 0);

    do_req(1'b0, 8'd3, d_at, sc, rc, mm);
    check("clr_done_at", d_at, 7);
    check("clr_r_cycles", rc, 2);
    check("clr_s_cycles", sc, 0);
    check("clr_mismatch", mm, 0);
    check("clr_q_fb", q_fb, 0);

    force_q0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      do_req(1'b1, 8'd0, d_at, sc, rc, mm);
      check("forced_mismatch", mm, 1);
      if (k == 2) check("forced_err3", err_cnt, 3);
    end
    check("forced_err5", err_cnt, 5);
    check("sat_err_final", err_cnt2, 3);
    force_q0 = 1'b0;

    wait_ready();
    req_val = 1'b0; req_gap = 8'd1; req_valid = 1'b1;
    dn = 0; last = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (done) begin
        if (dn > 0) check("b2b_spacing", i - last, 5);
        last = i;
        dn++;
        if (dn == 8) begin req_valid = 1'b0; break; end
        req_val = ~req_val;
      end
    end
    check("b2b_dones", dn, 8);
    extra = 0;
    repeat (20) begin @(negedge clk); if (done) extra++; end
    check("b2b_extra_done", extra, 0);

    wait_ready();
    req_val = 1'b1; req_gap = 8'd0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_s_before", s, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_s", s, 0);
    check("mid_r", r, 0);
    check("mid_done", done, 0);
    check("mid_err", err_cnt, 0);
    rst = 1'b0;
    extra = 0;
    repeat (10) begin @(negedge clk); if (done) extra++; end
    check("mid_no_done", extra, 0);

    do_req(1'b1, 8'd0, d_at, sc, rc, mm);
    check("post_done_at", d_at, 4);
    check("post_s_cycles", sc, 2);
    check("post_mismatch", mm, 0);
    check("post_err", err_cnt, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
